seg_scan_arb: RTL

SEG_SCAN_ARB -- requirements
Module: seg_scan_arb

---
 rtl/seg_pkg.sv | 34 +++
 rtl/seg_encode.sv | 35 +++
 rtl/seg_scan_arb.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants and types for the multiplexed 7-segment scan arbiter.
//   - Active-low segment codes for decimal digits 0..9 (bit7 = dp, segments a..g in bits 0..6)
//   - BLANK_CODE / NUM_DIGITS / bcd4_t digit-bundle type
//   - Scan FSM state encoding and a nibble-select helper
package seg_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] BLANK_CODE = 8'hFF;

  localparam logic [7:0] SEG_CODE_0 = 8'hC0;
  localparam logic [7:0] SEG_CODE_1 = 8'hF9;
  localparam logic [7:0] SEG_CODE_2 = 8'hA4;
  localparam logic [7:0] SEG_CODE_3 = 8'hB0;
  localparam logic [7:0] SEG_CODE_4 = 8'h99;
  localparam logic [7:0] SEG_CODE_5 = 8'h92;
  localparam logic [7:0] SEG_CODE_6 = 8'h82;
  localparam logic [7:0] SEG_CODE_7 = 8'hF8;
  localparam logic [7:0] SEG_CODE_8 = 8'h80;
  localparam logic [7:0] SEG_CODE_9 = 8'h90;

  // Four BCD digits, nibble k = digit k, k = 0 rightmost
  typedef logic [15:0] bcd4_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Pick digit k out of a four-digit bundle
  function automatic logic [3:0] nibble_sel(input bcd4_t v, input logic [1:0] k);
    nibble_sel = v[{k, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_encode.sv
// seg_encode: combinational BCD nibble + decimal point to active-low 8-bit segment code.
//   i_nibble : digit value; 0..9 map to the standard pattern, A..F show nothing
//   i_dp     : 1 lights the decimal point (clears bit7)
//   o_seg    : active-low segments, bit7 = dp
module seg_encode
  import seg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_dp,
  output logic [7:0] o_seg
);

  logic [7:0] w_code;

  // Digit value to segment pattern lookup
  always_comb begin
    w_code = BLANK_CODE;
    case (i_nibble)
      4'd0:    w_code = SEG_CODE_0;
      4'd1:    w_code = SEG_CODE_1;
      4'd2:    w_code = SEG_CODE_2;
      4'd3:    w_code = SEG_CODE_3;
      4'd4:    w_code = SEG_CODE_4;
      4'd5:    w_code = SEG_CODE_5;
      4'd6:    w_code = SEG_CODE_6;
      4'd7:    w_code = SEG_CODE_7;
      4'd8:    w_code = SEG_CODE_8;
      4'd9:    w_code = SEG_CODE_9;
      default: w_code = BLANK_CODE;
    endcase
  end

  assign o_seg = {w_code[7] & ~i_dp, w_code[6:0]};

endmodule

// File: rtl/seg_scan_arb.sv
// seg_scan_arb: two-requester arbiter sharing one 4-digit multiplexed 7-segment display.
//   clk, rst        : clock; asynchronous active-high reset
//   req[1:0]        : per-requester display request (level)
//   bcd0/bcd1       : requester digits, nibble k = digit k
//   dp0/dp1         : requester decimal points, bit k = digit k
//   gnt[1:0]        : current owner, one-hot or zero (registered)
//   seg[7:0]        : active-low segments, bit7 = dp (registered)
//   seg_an[3:0]     : active-low anode enables (registered)
//   frame_done      : one-cycle pulse after each completed owned frame (registered)
// Ownership only changes at frame boundaries; the owner's digits are snapshotted there so
// mid-frame data changes never tear a displayed frame.
module seg_scan_arb
  import seg_pkg::*;
#(
  parameter int CLK_HZ      = 1_000_000,
  parameter int SCAN_HZ     = 960,
  parameter int BLANK_CYC   = 4,
  parameter int HOLD_FRAMES = 240
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req,
  input  bcd4_t       bcd0,
  input  bcd4_t       bcd1,
  input  logic [3:0]  dp0,
  input  logic [3:0]  dp1,
  output logic [1:0]  gnt,
  output logic [7:0]  seg,
  output logic [3:0]  seg_an,
  output logic        frame_done
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W    = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam int HLD_W    = $clog2(HOLD_FRAMES + 1);
  localparam int IDX_W    = $clog2(NUM_DIGITS);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLANK_CYC - 1);
  localparam logic [HLD_W-1:0] HOLD_MAX  = HLD_W'(HOLD_FRAMES);
  localparam logic [HLD_W-1:0] HOLD_LAST = HLD_W'(HOLD_FRAMES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

  logic [DIV_W-1:0] r_div;
  logic [BLK_W-1:0] r_blank;
  logic [IDX_W-1:0] r_idx;
  logic [HLD_W-1:0] r_hold;
  scan_state_t      r_state;
  logic [1:0]       r_gnt;
  bcd4_t            r_snap_bcd;
  logic [3:0]       r_snap_dp;
  logic [7:0]       r_seg;
  logic [3:0]       r_an;
  logic             r_frame_done;

  logic [DIV_W-1:0] w_div_nxt;
  logic [BLK_W-1:0] w_blank_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [HLD_W-1:0] w_hold_nxt;
  scan_state_t      w_state_nxt;
  logic [1:0]       w_gnt_nxt;
  bcd4_t            w_snap_bcd_nxt;
  logic [3:0]       w_snap_dp_nxt;
  logic [7:0]       w_seg_nxt;
  logic [3:0]       w_an_nxt;
  logic [7:0]       w_enc;
  logic             w_tick;
  logic             w_has_owner;
  logic             w_boundary;
  logic             w_done;
  logic             w_hold_met;

  assign w_tick      = (r_div == DIV_LAST);
  assign w_has_owner = (r_gnt != 2'b00);
  // An owned frame ends after the last digit; with no owner every tick is an arbitration point
  assign w_boundary  = w_tick & (~w_has_owner | (r_idx == IDX_LAST));
  assign w_done      = w_boundary & w_has_owner;
  // The frame ending now counts as completed, hence the compare against HOLD_FRAMES-1
  assign w_hold_met  = (r_hold >= HOLD_LAST);

  // Owner selection at frame boundaries
  always_comb begin
    w_gnt_nxt = r_gnt;
    if (w_boundary) begin
      case (r_gnt)
        2'b00: begin
          if (req[0]) begin
            w_gnt_nxt = 2'b01;
          end else if (req[1]) begin
            w_gnt_nxt = 2'b10;
          end else begin
            w_gnt_nxt = 2'b00;
          end
        end
        2'b01: begin
          if (!req[0]) begin
            w_gnt_nxt = req[1] ? 2'b10 : 2'b00;
          end else if (req[1] && w_hold_met) begin
            w_gnt_nxt = 2'b10;
          end else begin
            w_gnt_nxt = 2'b01;
          end
        end
        2'b10: begin
          if (!req[1]) begin
            w_gnt_nxt = req[0] ? 2'b01 : 2'b00;
          end else if (req[0] && w_hold_met) begin
            w_gnt_nxt = 2'b01;
          end else begin
            w_gnt_nxt = 2'b10;
          end
        end
        default: w_gnt_nxt = 2'b00;
      endcase
    end else begin
      w_gnt_nxt = r_gnt;
    end
  end

  // Hold counter: frames completed by the current owner, saturating
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_boundary && (w_gnt_nxt != r_gnt)) begin
      w_hold_nxt = '0;
    end else if (w_done && (r_hold != HOLD_MAX)) begin
      w_hold_nxt = r_hold + HLD_W'(1'b1);
    end else begin
      w_hold_nxt = r_hold;
    end
  end

  // Snapshot the resulting owner's digits at each boundary
  always_comb begin
    w_snap_bcd_nxt = r_snap_bcd;
    w_snap_dp_nxt  = r_snap_dp;
    if (w_boundary) begin
      case (w_gnt_nxt)
        2'b01: begin
          w_snap_bcd_nxt = bcd0;
          w_snap_dp_nxt  = dp0;
        end
        2'b10: begin
          w_snap_bcd_nxt = bcd1;
          w_snap_dp_nxt  = dp1;
        end
        default: begin
          w_snap_bcd_nxt = r_snap_bcd;
          w_snap_dp_nxt  = r_snap_dp;
        end
      endcase
    end else begin
      w_snap_bcd_nxt = r_snap_bcd;
      w_snap_dp_nxt  = r_snap_dp;
    end
  end

  // Divider, scan phase and digit index
  always_comb begin
    w_div_nxt   = r_div;
    w_state_nxt = r_state;
    w_blank_nxt = r_blank;
    w_idx_nxt   = r_idx;
    if (w_tick) begin
      w_div_nxt   = '0;
      w_state_nxt = ST_BLANK;
      w_blank_nxt = '0;
      // A frame for an owner always starts at digit 0
      if (w_boundary && (w_gnt_nxt != 2'b00)) begin
        w_idx_nxt = '0;
      end else begin
        w_idx_nxt = r_idx + IDX_W'(1'b1);
      end
    end else begin
      w_div_nxt = r_div + DIV_W'(1'b1);
      case (r_state)
        ST_BLANK: begin
          if (r_blank == BLK_LAST) begin
            w_state_nxt = ST_DRIVE;
            w_blank_nxt = '0;
          end else begin
            w_blank_nxt = r_blank + BLK_W'(1'b1);
          end
        end
        ST_DRIVE: w_state_nxt = ST_DRIVE;
        default:  w_state_nxt = ST_BLANK;
      endcase
    end
  end

  seg_encode u_seg_encode (
    .i_nibble (nibble_sel(w_snap_bcd_nxt, w_idx_nxt)),
    .i_dp     (w_snap_dp_nxt[w_idx_nxt]),
    .o_seg    (w_enc)
  );

  // Display drive derived from next-state so registered outputs line up with the scan phase
  always_comb begin
    w_seg_nxt = BLANK_CODE;
    w_an_nxt  = 4'hF;
    if ((w_state_nxt == ST_DRIVE) && (w_gnt_nxt != 2'b00)) begin
      w_seg_nxt = w_enc;
      w_an_nxt  = ~(4'b0001 << w_idx_nxt);
    end else begin
      w_seg_nxt = BLANK_CODE;
      w_an_nxt  = 4'hF;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div        <= '0;
      r_blank      <= '0;
      r_idx        <= '0;
      r_hold       <= '0;
      r_state      <= ST_BLANK;
      r_gnt        <= 2'b00;
      r_snap_bcd   <= 16'h0000;
      r_snap_dp    <= 4'h0;
      r_seg        <= BLANK_CODE;
      r_an         <= 4'hF;
      r_frame_done <= 1'b0;
    end else begin
      r_div        <= w_div_nxt;
      r_blank      <= w_blank_nxt;
      r_idx        <= w_idx_nxt;
      r_hold       <= w_hold_nxt;
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_snap_bcd   <= w_snap_bcd_nxt;
      r_snap_dp    <= w_snap_dp_nxt;
      r_seg        <= w_seg_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_done;
    end
  end

  assign gnt        = r_gnt;
  assign seg        = r_seg;
  assign seg_an     = r_an;
  assign frame_done = r_frame_done;

endmodule
